// File: rtl/hub75_column_driver.sv
// hub75_column_driver
// Captures one column pair from the frame manager and drives a HUB75 panel
// using binary-coded modulation: per bitplane it shifts NUM_ROWS pixels,
// blanks, latches, then enables the LEDs for BASE_ON<<plane cycles.
//
// Ports:
//   clk_in       system clock
//   rst_in       asynchronous active-low reset
//   columns      [0] upper-half column, [1] lower-half column, {R,G,B} pixels
//   col_num1     scan address of the pair
//   col_num2     unused, kept for interface compatibility
//   data_valid   one-cycle strobe qualifying columns/col_num1
//   hub75_ready  one-cycle pulse requesting the next pair
//   rgb0/rgb1    {R,G,B} bits of the current plane for upper/lower half
//   addr         panel scan address
//   clk_out      panel shift clock
//   lat          panel latch
//   oe_n         panel output enable, active-low
//
// Every output is a flop. Each state's actions are registered, so the pins
// show a state's effect during the cycle after the state is evaluated.
module hub75_column_driver #(
    parameter int unsigned NUM_ROWS      = 64,
    parameter int unsigned SCAN_RATE     = 32,
    parameter int unsigned RGB_RES       = 9,
    parameter int unsigned BASE_ON       = 8,
    parameter int unsigned READY_TIMEOUT = 1024
) (
    input  logic                                     clk_in,
    input  logic                                     rst_in,
    input  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]    columns,
    input  logic [$clog2(SCAN_RATE)-1:0]             col_num1,
    input  logic [$clog2(SCAN_RATE):0]               col_num2,
    input  logic                                     data_valid,
    output logic                                     hub75_ready,
    output logic [2:0]                               rgb0,
    output logic [2:0]                               rgb1,
    output logic [$clog2(SCAN_RATE)-1:0]             addr,
    output logic                                     clk_out,
    output logic                                     lat,
    output logic                                     oe_n
);

    localparam int unsigned ADDR_W   = $clog2(SCAN_RATE);
    localparam int unsigned BPC      = RGB_RES / 3;
    localparam int unsigned PIX_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int unsigned PLANE_W  = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int unsigned SHOW_MAX = BASE_ON << (BPC - 1);
    localparam int unsigned SHOW_W   = $clog2(SHOW_MAX + 1);
    localparam int unsigned TMO_W    = $clog2(READY_TIMEOUT);

    typedef enum logic [2:0] {
        ST_REQ,
        ST_WAIT,
        ST_SHIFT,
        ST_BLANK,
        ST_LATCH,
        ST_SHOW
    } state_e;

    state_e                                  state_q, state_d;
    logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]   cols_q, cols_d;
    logic [ADDR_W-1:0]                       col_q, col_d;
    logic [PLANE_W-1:0]                      plane_q, plane_d;
    logic [PIX_W-1:0]                        pix_q, pix_d;
    logic                                    phase_q, phase_d;
    logic [TMO_W-1:0]                        tmo_q, tmo_d;
    logic [SHOW_W-1:0]                       show_q, show_d;

    logic                                    ready_q, ready_d;
    logic [2:0]                              rgb0_q, rgb0_d;
    logic [2:0]                              rgb1_q, rgb1_d;
    logic [ADDR_W-1:0]                       addr_q, addr_d;
    logic                                    clk_out_q, clk_out_d;
    logic                                    lat_q, lat_d;
    logic                                    oe_n_q, oe_n_d;

    logic [SHOW_W-1:0]                       show_len_c;
    logic                                    unused_col_num2;

    assign unused_col_num2 = ^col_num2;

    // On-time of the current bitplane: binary weighting of BASE_ON.
    assign show_len_c = SHOW_W'(BASE_ON) << plane_q;

    // Pick bit `pl` of each colour channel of a packed {R,G,B} pixel.
    function automatic logic [2:0] plane_bits(input logic [RGB_RES-1:0] px,
                                              input logic [PLANE_W-1:0] pl);
        logic [BPC-1:0] r;
        logic [BPC-1:0] g;
        logic [BPC-1:0] b;
        r = px[3*BPC-1 -: BPC];
        g = px[2*BPC-1 -: BPC];
        b = px[BPC-1:0];
        return {r[pl], g[pl], b[pl]};
    endfunction

    // Next-state and registered-output decode.
    always_comb begin
        state_d   = state_q;
        cols_d    = cols_q;
        col_d     = col_q;
        plane_d   = plane_q;
        pix_d     = pix_q;
        phase_d   = phase_q;
        tmo_d     = tmo_q;
        show_d    = show_q;
        ready_d   = 1'b0;
        rgb0_d    = rgb0_q;
        rgb1_d    = rgb1_q;
        addr_d    = addr_q;
        clk_out_d = 1'b0;
        lat_d     = 1'b0;
        oe_n_d    = 1'b1;

        unique case (state_q)
            ST_REQ: begin
                ready_d = 1'b1;
                tmo_d   = '0;
                state_d = ST_WAIT;
            end

            // Capture has priority over the timeout on the expiry cycle.
            // Expiry at READY_TIMEOUT-2 makes the ready period READY_TIMEOUT
            // once the REQ cycle is counted.
            ST_WAIT: begin
                if (data_valid) begin
                    cols_d  = columns;
                    col_d   = col_num1;
                    plane_d = '0;
                    pix_d   = '0;
                    phase_d = 1'b0;
                    state_d = ST_SHIFT;
                end else if (tmo_q == TMO_W'(READY_TIMEOUT - 2)) begin
                    state_d = ST_REQ;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            // Phase A presents data with clk_out low, phase B raises clk_out.
            ST_SHIFT: begin
                if (!phase_q) begin
                    rgb0_d  = plane_bits(cols_q[0][pix_q], plane_q);
                    rgb1_d  = plane_bits(cols_q[1][pix_q], plane_q);
                    phase_d = 1'b1;
                end else begin
                    clk_out_d = 1'b1;
                    phase_d   = 1'b0;
                    if (pix_q == PIX_W'(NUM_ROWS - 1)) begin
                        pix_d   = '0;
                        state_d = ST_BLANK;
                    end else begin
                        pix_d = pix_q + PIX_W'(1);
                    end
                end
            end

            ST_BLANK: begin
                addr_d  = col_q;
                state_d = ST_LATCH;
            end

            ST_LATCH: begin
                lat_d   = 1'b1;
                show_d  = '0;
                state_d = ST_SHOW;
            end

            ST_SHOW: begin
                oe_n_d = 1'b0;
                if (show_q == show_len_c - SHOW_W'(1)) begin
                    if (plane_q == PLANE_W'(BPC - 1)) begin
                        state_d = ST_REQ;
                    end else begin
                        plane_d = plane_q + PLANE_W'(1);
                        pix_d   = '0;
                        phase_d = 1'b0;
                        state_d = ST_SHIFT;
                    end
                end else begin
                    show_d = show_q + SHOW_W'(1);
                end
            end

            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= ST_REQ;
            cols_q    <= '0;
            col_q     <= '0;
            plane_q   <= '0;
            pix_q     <= '0;
            phase_q   <= 1'b0;
            tmo_q     <= '0;
            show_q    <= '0;
            ready_q   <= 1'b0;
            rgb0_q    <= '0;
            rgb1_q    <= '0;
            addr_q    <= '0;
            clk_out_q <= 1'b0;
            lat_q     <= 1'b0;
            oe_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cols_q    <= cols_d;
            col_q     <= col_d;
            plane_q   <= plane_d;
            pix_q     <= pix_d;
            phase_q   <= phase_d;
            tmo_q     <= tmo_d;
            show_q    <= show_d;
            ready_q   <= ready_d;
            rgb0_q    <= rgb0_d;
            rgb1_q    <= rgb1_d;
            addr_q    <= addr_d;
            clk_out_q <= clk_out_d;
            lat_q     <= lat_d;
            oe_n_q    <= oe_n_d;
        end
    end

    assign hub75_ready = ready_q;
    assign rgb0        = rgb0_q;
    assign rgb1        = rgb1_q;
    assign addr        = addr_q;
    assign clk_out     = clk_out_q;
    assign lat         = lat_q;
    assign oe_n        = oe_n_q;

endmodule

// File: tb/tb_hub75_column_driver.sv
// Self-checking bench for hub75_column_driver: random column pairs are
// compared against a pixel/bitplane reference model computed in the bench.
module tb_hub75_column_driver;

    localparam int unsigned NR     = 64;
    localparam int unsigned SR     = 32;
    localparam int unsigned RES    = 9;
    localparam int unsigned BPC    = RES / 3;
    localparam int unsigned BASE   = 8;
    localparam int unsigned RT     = 1024;
    localparam int unsigned ADDR_W = $clog2(SR);
    // Capture edge to next ready pulse: shift, blank, latch per plane,
    // binary-weighted on-time, then one REQ cycle.
    localparam int EXP_LAT = 2*NR*BPC + 2*BPC + BASE*((1 << BPC) - 1) + 1;
    localparam int BUDGET  = EXP_LAT + 200;

    logic                              clk_in;
    logic                              rst_in;
    logic [1:0][NR-1:0][RES-1:0]       columns;
    logic [ADDR_W-1:0]                 col_num1;
    logic [ADDR_W:0]                   col_num2;
    logic                              data_valid;
    logic                              hub75_ready;
    logic [2:0]                        rgb0;
    logic [2:0]                        rgb1;
    logic [ADDR_W-1:0]                 addr;
    logic                              clk_out;
    logic                              lat;
    logic                              oe_n;

    int                                n_tests;
    int                                n_fail;
    logic [1:0][NR-1:0][RES-1:0]       stim_cols;
    logic [1:0][NR-1:0][RES-1:0]       alt_cols;
    logic [ADDR_W-1:0]                 stim_col;
    logic [ADDR_W-1:0]                 alt_col;
    logic [ADDR_W-1:0]                 cur_addr;

    hub75_column_driver #(
        .NUM_ROWS      (NR),
        .SCAN_RATE     (SR),
        .RGB_RES       (RES),
        .BASE_ON       (BASE),
        .READY_TIMEOUT (RT)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .columns     (columns),
        .col_num1    (col_num1),
        .col_num2    (col_num2),
        .data_valid  (data_valid),
        .hub75_ready (hub75_ready),
        .rgb0        (rgb0),
        .rgb1        (rgb1),
        .addr        (addr),
        .clk_out     (clk_out),
        .lat         (lat),
        .oe_n        (oe_n)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Reference: bit b of R, G and B of a packed {R,G,B} pixel.
    function automatic logic [2:0] exp_bits(input logic [RES-1:0] px, input int b);
        logic [RES-1:0] t;
        t = px >> b;
        return {t[2*BPC], t[BPC], t[0]};
    endfunction

    task automatic randomize_stim();
        for (int s = 0; s < 2; s++)
            for (int p = 0; p < NR; p++)
                stim_cols[s][p] = RES'($urandom);
        stim_col = ADDR_W'($urandom_range(0, SR - 1));
    endtask

    // Advance to a sample point where hub75_ready is high.
    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        if (hub75_ready) begin
            ok = 1'b1;
            return;
        end
        for (int k = 0; k < int'(RT) + 50; k++) begin
            @(posedge clk_in); #1;
            if (hub75_ready) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // One full pair: request, capture stim_cols/stim_col, observe all planes.
    task automatic test_pair(input string name, input int inject_at, input bit at_expiry);
        bit          ok;
        logic [2:0]  q0[$];
        logic [2:0]  q1[$];
        int          runs[$];
        int          lat_n, lat_bad, viol, early_bad, lowcnt, latency, early;
        logic        prev_clk;

        wait_ready(ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s ready_wait: no hub75_ready within %0d cycles", name, RT + 50);
            return;
        end
        if (at_expiry) begin
            early = 0;
            repeat (RT - 2) begin
                @(posedge clk_in); #1;
                if (hub75_ready) early++;
            end
            n_tests++;
            if (early !== 0) begin
                n_fail++;
                $display("FAIL %s early_ready: got %0d pulses, want 0", name, early);
            end
        end
        data_valid = 1'b1;
        columns    = stim_cols;
        col_num1   = stim_col;
        @(posedge clk_in); #1;
        data_valid = 1'b0;

        lat_n = 0; lat_bad = 0; viol = 0; early_bad = 0; lowcnt = 0; latency = -1;
        prev_clk = clk_out;
        for (int k = 1; k <= BUDGET; k++) begin
            @(posedge clk_in); #1;
            if (k == inject_at) begin
                data_valid = 1'b1;
                columns    = alt_cols;
                col_num1   = alt_col;
            end else begin
                data_valid = 1'b0;
            end
            if (clk_out && !prev_clk) begin
                q0.push_back(rgb0);
                q1.push_back(rgb1);
            end
            prev_clk = clk_out;
            if (lat) begin
                lat_n++;
                if (addr !== stim_col) lat_bad++;
            end
            if (lat && (clk_out || !oe_n)) viol++;
            if (k <= 2*NR && addr !== cur_addr) early_bad++;
            if (!oe_n) lowcnt++;
            else if (lowcnt > 0) begin
                runs.push_back(lowcnt);
                lowcnt = 0;
            end
            if (hub75_ready) begin
                latency = k;
                break;
            end
        end
        data_valid = 1'b0;

        n_tests++;
        if (latency !== EXP_LAT) begin
            n_fail++;
            $display("FAIL %s ready_latency: got %0d, want %0d", name, latency, EXP_LAT);
        end
        n_tests++;
        if (q0.size() !== NR*BPC) begin
            n_fail++;
            $display("FAIL %s clk_edges: got %0d, want %0d", name, q0.size(), NR*BPC);
        end
        for (int i = 0; i < NR*BPC && i < q0.size(); i++) begin
            n_tests++;
            if (q0[i] !== exp_bits(stim_cols[0][i % NR], i / NR) ||
                q1[i] !== exp_bits(stim_cols[1][i % NR], i / NR)) begin
                n_fail++;
                $display("FAIL %s rgb plane %0d pix %0d: got %b/%b, want %b/%b", name,
                         i / NR, i % NR, q0[i], q1[i],
                         exp_bits(stim_cols[0][i % NR], i / NR),
                         exp_bits(stim_cols[1][i % NR], i / NR));
            end
        end
        n_tests++;
        if (lat_n !== BPC || lat_bad !== 0) begin
            n_fail++;
            $display("FAIL %s latch: got %0d pulses (%0d bad addr), want %0d pulses at addr %0d",
                     name, lat_n, lat_bad, BPC, stim_col);
        end
        n_tests++;
        if (viol !== 0) begin
            n_fail++;
            $display("FAIL %s lat_overlap: got %0d cycles, want 0", name, viol);
        end
        n_tests++;
        if (early_bad !== 0) begin
            n_fail++;
            $display("FAIL %s addr_stable: got %0d changed cycles, want 0 (addr %0d)",
                     name, early_bad, cur_addr);
        end
        n_tests++;
        if (runs.size() !== BPC) begin
            n_fail++;
            $display("FAIL %s oe_runs: got %0d, want %0d", name, runs.size(), BPC);
        end
        for (int b = 0; b < BPC && b < runs.size(); b++) begin
            n_tests++;
            if (runs[b] !== int'(BASE << b)) begin
                n_fail++;
                $display("FAIL %s oe_len plane %0d: got %0d, want %0d", name, b, runs[b], BASE << b);
            end
        end
        cur_addr = stim_col;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        n_tests++;
        if ({hub75_ready, rgb0, rgb1, addr, clk_out, lat, oe_n} !== {1'b0, 6'b0, ADDR_W'(0), 3'b001}) begin
            n_fail++;
            $display("FAIL reset_values: got rdy=%b rgb=%b/%b addr=%0d clk=%b lat=%b oe_n=%b",
                     hub75_ready, rgb0, rgb1, addr, clk_out, lat, oe_n);
        end
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        n_tests++;
        if (hub75_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL first_req: got %b, want 1", hub75_ready);
        end
        @(posedge clk_in); #1;
        n_tests++;
        if (hub75_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL req_width: got %b, want 0", hub75_ready);
        end
        cur_addr = '0;
    endtask

    task automatic test_solid();
        for (int p = 0; p < NR; p++) begin
            stim_cols[0][p] = '1;
            stim_cols[1][p] = '0;
        end
        stim_col = ADDR_W'(5);
        test_pair("solid", 0, 1'b0);
    endtask

    task automatic test_bitplanes();
        randomize_stim();
        for (int p = 0; p < NR; p++) stim_cols[0][p] = 9'b100_010_001;
        test_pair("bitplanes", 0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 3; n++) begin
            randomize_stim();
            test_pair("random", 0, 1'b0);
        end
    endtask

    // data_valid during SHIFT must be ignored, and nothing starts until a capture.
    task automatic test_ignore_busy();
        int act;
        randomize_stim();
        alt_cols = ~stim_cols;
        alt_col  = ~stim_col;
        test_pair("ignore_busy", 37, 1'b0);
        act = 0;
        repeat (20) begin
            @(posedge clk_in); #1;
            if (clk_out || lat || !oe_n) act++;
        end
        n_tests++;
        if (act !== 0) begin
            n_fail++;
            $display("FAIL idle_after_pair: got %0d active cycles, want 0", act);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int gap;
        wait_ready(ok);
        gap = -1;
        for (int k = 1; k <= int'(RT) + 50; k++) begin
            @(posedge clk_in); #1;
            if (hub75_ready) begin
                gap = k;
                break;
            end
        end
        n_tests++;
        if (!ok || gap !== int'(RT)) begin
            n_fail++;
            $display("FAIL timeout_period: got %0d (start ok=%b), want %0d", gap, ok, RT);
        end
        randomize_stim();
        test_pair("expiry_capture", 0, 1'b1);
    endtask

    task automatic test_reset_mid();
        bit ok;
        randomize_stim();
        while (stim_col == cur_addr || stim_col == '0) stim_col = ADDR_W'($urandom_range(1, SR - 1));
        wait_ready(ok);
        data_valid = 1'b1;
        columns    = stim_cols;
        col_num1   = stim_col;
        @(posedge clk_in); #1;
        data_valid = 1'b0;
        repeat (2*NR + 2 + BASE + 20) @(posedge clk_in);
        #1;
        n_tests++;
        if (!ok || addr !== stim_col) begin
            n_fail++;
            $display("FAIL addr_before_reset: got %0d (ok=%b), want %0d", addr, ok, stim_col);
        end
        #2 rst_in = 1'b0;
        #1;
        n_tests++;
        if ({hub75_ready, rgb0, rgb1, addr, clk_out, lat, oe_n} !== {1'b0, 6'b0, ADDR_W'(0), 3'b001}) begin
            n_fail++;
            $display("FAIL async_reset: got rdy=%b rgb=%b/%b addr=%0d clk=%b lat=%b oe_n=%b",
                     hub75_ready, rgb0, rgb1, addr, clk_out, lat, oe_n);
        end
        repeat (2) @(posedge clk_in);
        #1;
        rst_in   = 1'b1;
        cur_addr = '0;
        @(posedge clk_in); #1;
        n_tests++;
        if (hub75_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL req_after_reset: got %b, want 1", hub75_ready);
        end
        randomize_stim();
        test_pair("after_reset", 0, 1'b0);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst_in     = 1'b0;
        data_valid = 1'b0;
        columns    = '0;
        col_num1   = '0;
        col_num2   = '0;
        stim_cols  = '0;
        alt_cols   = '0;
        stim_col   = '0;
        alt_col    = '0;
        cur_addr   = '0;
        test_reset();
        test_solid();
        test_bitplanes();
        test_random();
        test_ignore_busy();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hub75_column_driver.md
Name: hub75_column_driver

Overview:
- Sits directly downstream of the frame manager, which supplies two columns per handshake: col_num1 and col_num1+SCAN_RATE.
- Captures the column pair and drives the HUB75 panel pins. For each bitplane it serially shifts NUM_ROWS pixels, then blanks, latches and enables output.
- Uses binary-coded modulation for colour depth.
- Pulses hub75_ready once per column pair so the frame manager streams the next pair.

Parameters:
- NUM_ROWS, 64, pixels per column (shift length)
- SCAN_RATE, 32, column pairs per rotation step; addr width = $clog2(SCAN_RATE)
- RGB_RES, 9, bits per pixel, packed {R,G,B}; BPC = RGB_RES/3 bits per channel (bitplanes)
- BASE_ON, 8, oe_n-low cycles for bitplane 0; plane b lasts BASE_ON<<b
- READY_TIMEOUT, 1024, cycles to wait for data_valid before re-pulsing hub75_ready

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-low reset
- columns  input  [1:0][NUM_ROWS-1:0][RGB_RES-1:0]  [0] = upper-half column, [1] = lower-half column
- col_num1  input  $clog2(SCAN_RATE)  scan address of the pair
- col_num2  input  $clog2(SCAN_RATE)+1  accepted for interface compatibility, unused
- data_valid  input  1  one-cycle strobe: columns/col_num1 valid
- hub75_ready  output  1  one-cycle pulse requesting next pair
- rgb0  output  3  {R,G,B} bits for upper half
- rgb1  output  3  {R,G,B} bits for lower half
- addr  output  $clog2(SCAN_RATE)  panel scan address
- clk_out  output  1  panel shift clock
- lat  output  1  panel latch
- oe_n  output  1  panel output enable, active-low

Behaviour:
- Reset (rst_in=0, asynchronous):
  - State = REQ.
  - hub75_ready=0, rgb0=rgb1=0, addr=0, clk_out=0, lat=0, oe_n=1.
  - Capture registers, plane counter, pixel counter and timeout counter cleared.
- All outputs are registered.

State machine:
- REQ:
  - Assert hub75_ready for exactly one cycle; go to WAIT.
  - First REQ occurs in the first cycle after reset release.
- WAIT:
  - hub75_ready=0, oe_n=1.
  - On data_valid=1: capture columns and col_num1, set plane=0, pix=0, go to SHIFT.
  - If READY_TIMEOUT cycles elapse without data_valid, go to REQ. The counter clears on entry to WAIT.
- SHIFT: two cycles per pixel.
  - Phase A: clk_out=0; rgb0 = bit `plane` of R,G,B of captured[0][pix]; rgb1 likewise from captured[1][pix].
  - Phase B: clk_out=1, rgb held.
  - Pixel order is pix=0 to NUM_ROWS-1, giving 2*NUM_ROWS cycles per plane.
  - After phase B of pix=NUM_ROWS-1, clk_out=0 and go to BLANK.
- BLANK (1 cycle):
  - oe_n=1, addr <= captured col_num1, go to LATCH.
- LATCH (1 cycle):
  - lat=1, oe_n=1, go to SHOW. lat returns to 0 next cycle.
- SHOW:
  - oe_n=0 for exactly BASE_ON<<plane cycles.
  - Then oe_n=1. If plane < BPC-1: plane++, pix=0, go to SHIFT; else go to REQ.
- Per-pair cycle count (defaults): 3*(128+1+1) + 8*(1+2+4) = 446, plus REQ/WAIT overhead.

Invariants and boundaries:
- oe_n=1 whenever lat=1 or state≠SHOW. lat is never high with clk_out high.
- data_valid in any state other than WAIT is ignored; captured data is never overwritten mid-sequence.
- data_valid coincident with the timeout expiry cycle: capture wins; go to SHIFT, not REQ.
- addr changes only in BLANK. The previous address stays stable through SHIFT of the next pair (the previous image remains latched, with oe_n=1).
- col_num1 ≥ SCAN_RATE cannot occur, since the width enforces the range.
- Reset asserted mid-sequence: all outputs return to reset values immediately (asynchronously). The partial pair is discarded; a new REQ is issued after release.
- Stale columns delivered with data_valid (frame manager skipped the column) are displayed as received; this is not an error.

Test Plan:
- Reset release → hub75_ready high exactly one cycle, in the first cycle after release; while reset is low: oe_n=1, lat=0, clk_out=0, addr=0.
- data_valid with col_num1=5, columns[0][all]=9'h1FF, columns[1][all]=9'h000 → 64 clk_out rising edges per plane; rgb0=3'b111 and rgb1=3'b000 at every edge; after the first LATCH, addr=5; one lat pulse per plane (3 total).
- Pixel pattern columns[0][p]=9'b100_010_001 → rgb0 across planes 0/1/2 = {R,G,B} 3'b001, 3'b010, 3'b100; oe_n low for exactly 8, 16, 32 cycles; hub75_ready pulses 446 cycles after capture (± REQ/WAIT cycles per the state trace).
- data_valid asserted during SHIFT with different data → ignored; displayed data and addr unchanged; the next capture happens only after the following hub75_ready.
- No data_valid after hub75_ready → a new hub75_ready pulse follows exactly READY_TIMEOUT cycles later (1024); data_valid on the expiry cycle → captured, no extra ready pulse.
- rst_in driven low mid-SHIFT of plane 1 (asynchronous, between clock edges) → outputs reach reset values before the next clk_in edge; after release, a fresh REQ pulse occurs and the full 3-plane sequence runs for the new data.
